// File: rtl/plp_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : plp_mem_pkg
//  Description : Shared constants, FSM state encodings and FIFO entry layout
//                for the ROM prefetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package plp_mem_pkg;

    localparam int          ROM_WORDS = 512;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FULL  = 2'd1,
        S_FLUSH = 2'd2
    } pf_state_e;

    // FIFO entry is packed as {fault, pc[31:0], inst[data_w-1:0]}
    function automatic int entry_w(input int data_w);
        return 1 + 32 + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_prefetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_prefetch_unit_if
//  Description : CPU fetch stream, redirect and ROM port A signals of the
//                prefetch unit. master = prefetch unit, slave = CPU/ROM side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rom_prefetch_unit_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [31:0]       inst_pc;
    logic              inst_fault;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (
        input  redirect, redirect_pc, inst_ready, rom_data,
        output inst_valid, inst, inst_pc, inst_fault, rom_en, rom_addr
    );

    modport slave (
        output redirect, redirect_pc, inst_ready, rom_data,
        input  inst_valid, inst, inst_pc, inst_fault, rom_en, rom_addr
    );
endinterface
`default_nettype wire

// File: rtl/rom_prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rom_prefetch_fifo
//  Description : Synchronous FIFO with flush and occupancy count; head output
//                reads zero while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_flush,
    input  wire logic                   i_push,
    input  wire logic                   i_pop,
    input  wire logic [WIDTH-1:0]       i_din,
    output logic      [WIDTH-1:0]       o_dout,
    output logic      [$clog2(DEPTH):0] o_count
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(i_push) - c_cnt_w'(i_pop);
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    assign o_dout  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/rom_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rom_prefetch_unit
//  Description : Sequential instruction prefetch from boot ROM port A with
//                credit-based issue, PC redirect/flush and a small FIFO.
//                Optional macro ROM_RANGE_CHECK_EN: out-of-window PCs become
//                faulting NOPs instead of aliased ROM reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_prefetch_unit
    import plp_mem_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 9,
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rom_prefetch_unit_if.master bus
);
    localparam int c_cnt_w   = $clog2(DEPTH) + 1;
    localparam int c_sum_w   = c_cnt_w + 1;
    localparam int c_entry_w = entry_w(DATA_W);

    pf_state_e          r_state;
    pf_state_e          w_state_next;

    logic [31:0]        r_fetch_pc;
    logic               r_issue;
    logic               r_issue_fault;
    logic [31:0]        r_issue_pc;
    logic               r_rom_en;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic               r_resp_valid;
    logic               r_resp_fault;
    logic [31:0]        r_resp_pc;

    logic               w_push;
    logic               w_pop;
    logic               w_credit;
    logic               w_issue;
    logic               w_sel_fault;
    logic [31:0]        w_sel_pc;
    logic [c_cnt_w-1:0] w_count;
    logic [c_cnt_w-1:0] w_count_next;
    logic [c_sum_w-1:0] w_credit_sum;
    logic [c_entry_w-1:0] w_push_entry;
    logic [c_entry_w-1:0] w_head_entry;
    logic [DATA_W-1:0]  w_push_inst;

    // A redirect discards this cycle's response and head pop
    assign w_push = r_resp_valid & ~bus.redirect;
    assign w_pop  = (w_count != '0) & bus.inst_ready & ~bus.redirect;

    // Everything that could still land in the FIFO must fit behind the
    // post-update occupancy before another request is launched
    assign w_count_next = w_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    assign w_credit_sum = c_sum_w'(w_count_next) + c_sum_w'(r_issue)
                        + c_sum_w'(r_resp_valid);
    assign w_credit     = (w_credit_sum < c_sum_w'(DEPTH));

    assign w_sel_pc = bus.redirect ? (bus.redirect_pc & 32'hFFFF_FFFC) : r_fetch_pc;

`ifdef ROM_RANGE_CHECK_EN
    assign w_sel_fault = |(w_sel_pc >> (ADDR_W + 2));
`else
    assign w_sel_fault = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        if (bus.redirect) begin
            w_state_next = S_FLUSH;
            w_issue      = 1'b1;
        end else begin
            case (r_state)
                S_FLUSH: begin
                    w_issue      = w_credit;
                    w_state_next = S_RUN;
                end
                S_RUN, S_FULL: begin
                    w_issue      = w_credit;
                    w_state_next = w_credit ? S_RUN : S_FULL;
                end
                default: begin
                    w_state_next = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_fetch_pc    <= RESET_PC;
            r_issue       <= 1'b0;
            r_issue_fault <= 1'b0;
            r_issue_pc    <= '0;
            r_rom_en      <= 1'b0;
            r_rom_addr    <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_fault  <= 1'b0;
            r_resp_pc     <= '0;
        end else begin
            r_state      <= w_state_next;
            r_resp_valid <= r_issue & ~bus.redirect;
            r_resp_fault <= r_issue_fault;
            r_resp_pc    <= r_issue_pc;
            r_issue      <= w_issue;
            r_rom_en     <= w_issue & ~w_sel_fault;
            if (w_issue) begin
                r_issue_pc    <= w_sel_pc;
                r_issue_fault <= w_sel_fault;
                r_fetch_pc    <= w_sel_pc + 32'd4;
                if (!w_sel_fault) begin
                    r_rom_addr <= w_sel_pc[ADDR_W+1:2];
                end
            end
        end
    end

    assign w_push_inst  = r_resp_fault ? DATA_W'(NOP_WORD) : bus.rom_data;
    assign w_push_entry = {r_resp_fault, r_resp_pc, w_push_inst};

    rom_prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_push_entry),
        .o_dout  (w_head_entry),
        .o_count (w_count)
    );

    assign bus.inst_valid = (w_count != '0);
    assign bus.inst_fault = w_head_entry[c_entry_w-1];
    assign bus.inst_pc    = w_head_entry[DATA_W+31:DATA_W];
    assign bus.inst       = w_head_entry[DATA_W-1:0];
    assign bus.rom_en     = r_rom_en;
    assign bus.rom_addr   = r_rom_addr;

endmodule
`default_nettype wire

// File: tb/tb_rom_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_prefetch_unit
//  Description : Directed self-checking bench for rom_prefetch_unit with a
//                one-cycle-latency ROM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_prefetch_unit;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rom_prefetch_unit_if #(.ADDR_W(9), .DATA_W(32)) bus ();

    rom_prefetch_unit #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (9),
        .DATA_W   (32),
        .DEPTH    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] exp_word(input int i);
        return (i == 99) ? 32'h0C00_002C : (32'hA500_0000 | 32'(i));
    endfunction

    logic [31:0] rom [512];
    initial begin
        for (int i = 0; i < 512; i++) rom[i] = exp_word(i);
    end

    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
        chk({tag, "_inst"},  bus.inst,            32'd0);
        chk({tag, "_pc"},    bus.inst_pc,         32'd0);
        chk({tag, "_fault"}, 32'(bus.inst_fault), 32'd0);
        chk({tag, "_en"},    32'(bus.rom_en),     32'd0);
        chk({tag, "_addr"},  32'(bus.rom_addr),   32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.inst_ready  = 1'b1;
        repeat (3) tick();
        chk_reset("rst0");
        rst = 1'b0;

        // Streaming with a consumer that always accepts
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk("t1_en",    32'(bus.rom_en),     32'd1);
            chk("t1_addr",  32'(bus.rom_addr),   32'(c - 1));
            chk("t1_valid", 32'(bus.inst_valid), (c >= 3) ? 32'd1 : 32'd0);
            if (c >= 3) begin
                chk("t1_pc",   bus.inst_pc, 32'(4 * (c - 3)));
                chk("t1_inst", bus.inst,    exp_word(c - 3));
            end
        end

        // Stall until the FIFO fills, then reset mid-stream
        bus.inst_ready = 1'b0;
        repeat (8) tick();
        chk("t5_full_en",    32'(bus.rom_en),     32'd0);
        chk("t5_full_valid", 32'(bus.inst_valid), 32'd1);
        chk("t5_full_pc",    bus.inst_pc,         32'd28);
        chk("t5_full_inst",  bus.inst,            exp_word(7));
        rst = 1'b1;
        tick();
        chk_reset("rst1");
        rst = 1'b0;

        // Fill from reset with consumer stalled for ten cycles
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) begin
                chk("t2_restart_en",   32'(bus.rom_en),   32'd1);
                chk("t2_restart_addr", 32'(bus.rom_addr), 32'd0);
            end
        end
        chk("t2_hold_en",    32'(bus.rom_en),     32'd0);
        chk("t2_hold_valid", 32'(bus.inst_valid), 32'd1);
        chk("t2_hold_pc",    bus.inst_pc,         32'd0);
        chk("t2_hold_inst",  bus.inst,            exp_word(0));
        bus.inst_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) chk("t2_resume_addr", 32'(bus.rom_addr), 32'd4);
            chk("t2_valid", 32'(bus.inst_valid), 32'd1);
            chk("t2_pc",    bus.inst_pc,         32'(4 * k));
            chk("t2_inst",  bus.inst,            exp_word(k));
        end

        // Redirect into a partially filled FIFO with a request in flight
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        tick();
        bus.redirect = 1'b0;
        chk("t3a_valid", 32'(bus.inst_valid), 32'd0);
        chk("t3a_addr",  32'(bus.rom_addr),   32'd64);
        repeat (5) tick();
        chk("t3a_en",    32'(bus.rom_en),     32'd1);
        chk("t3a_addr2", 32'(bus.rom_addr),   32'd67);
        chk("t3a_pc",    bus.inst_pc,         32'h0000_0100);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_018E;
        tick();
        bus.redirect = 1'b0;
        chk("t3_valid0", 32'(bus.inst_valid), 32'd0);
        chk("t3_en",     32'(bus.rom_en),     32'd1);
        chk("t3_addr",   32'(bus.rom_addr),   32'd99);
        tick();
        chk("t3_valid1", 32'(bus.inst_valid), 32'd0);
        tick();
        chk("t3_valid2", 32'(bus.inst_valid), 32'd1);
        chk("t3_inst",   bus.inst,            32'h0C00_002C);
        chk("t3_pc",     bus.inst_pc,         32'h0000_018C);
        bus.inst_ready = 1'b1;
        tick();
        chk("t3_pc_n1",   bus.inst_pc, 32'h0000_0190);
        chk("t3_inst_n1", bus.inst,    exp_word(100));
        tick();
        chk("t3_pc_n2",   bus.inst_pc, 32'h0000_0194);
        chk("t3_inst_n2", bus.inst,    exp_word(101));

        // ROM word-address wrap
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_07FC;
        tick();
        bus.redirect = 1'b0;
        chk("t4_addr0", 32'(bus.rom_addr), 32'd511);
        tick();
`ifdef ROM_RANGE_CHECK_EN
        chk("t4_en1",   32'(bus.rom_en),   32'd0);
`else
        chk("t4_addr1", 32'(bus.rom_addr), 32'd0);
`endif
        tick();
        chk("t4_pc0",   bus.inst_pc, 32'h0000_07FC);
        chk("t4_inst0", bus.inst,    exp_word(511));
        tick();
        chk("t4_pc1",   bus.inst_pc, 32'h0000_0800);
`ifdef ROM_RANGE_CHECK_EN
        chk("t4_inst1",  bus.inst,            32'd0);
        chk("t4_fault1", 32'(bus.inst_fault), 32'd1);
`else
        chk("t4_inst1",  bus.inst,            exp_word(0));
        chk("t4_fault1", 32'(bus.inst_fault), 32'd0);
`endif

        // PC outside the ROM window
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hF000_0000;
        tick();
        bus.redirect = 1'b0;
`ifdef ROM_RANGE_CHECK_EN
        chk("t6_en", 32'(bus.rom_en), 32'd0);
`else
        chk("t6_en",   32'(bus.rom_en),   32'd1);
        chk("t6_addr", 32'(bus.rom_addr), 32'd0);
`endif
        repeat (2) tick();
        chk("t6_valid", 32'(bus.inst_valid), 32'd1);
        chk("t6_pc",    bus.inst_pc,         32'hF000_0000);
`ifdef ROM_RANGE_CHECK_EN
        chk("t6_inst",  bus.inst,            32'd0);
        chk("t6_fault", 32'(bus.inst_fault), 32'd1);
`else
        chk("t6_inst",  bus.inst,            exp_word(0));
        chk("t6_fault", 32'(bus.inst_fault), 32'd0);
`endif
        tick();
        chk("t6_pc_n1", bus.inst_pc, 32'hF000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
